tile_layer: RTL and testbench
=============================

# tile_layer

Parametrised tile-map layer renderer for the LCD pixel pipeline. On each rising edge of the LCD pixel clock it takes the current pixel coordinate, applies scroll offsets, looks up the tile index in the generator (tile-map) RAM, then looks up the texel in the tile ROM with optional mirror and 90° rotation. It presents a colour plus an active flag to the layer mixer. Tile size, map width, colour width, index width and memory read latency are all parameters. Uniform latency, a transparent-index check, a pixel-valid strobe and overrun detection are part of the block.

## Interface
- TILE_SHIFT, 2: log2 of the tile side T; T = 2^TILE_SHIFT.
- MAP_COLS, 120: tiles per map row.
- X_W, 9: width of x, y and scroll coordinates.
- IDX_W, 6: tile index width.
- COLOR_W, 24: texel colour width.
- GEN_AW, 13: generator address width.
- MEM_LAT, 1: read latency of both memories in cycles (≥1).
- TRANSPARENT, 2^IDX_W-1: tile index rendered as transparent.
- Derived: ROM_AW = IDX_W + 2*TILE_SHIFT.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_lcd_clk  in  1  LCD pixel clock, sampled as data in i_clk.
- i_x, i_y  in  X_W  current pixel coordinate.
- i_scroll_x, i_scroll_y  in  X_W  scroll offsets.
- i_rotate  in  2  0=0°, 1=90°, 2=180°, 3=270°.
- i_mirror  in  1  horizontal mirror of the texel, applied before rotation.
- i_gen_data  in  IDX_W  generator read data.
- i_rom_data  in  COLOR_W  tile ROM read data.
- i_overrun_clr  in  1  clears o_overrun.
- o_gen_addr  out  GEN_AW  generator read address (registered).
- o_rom_addr  out  ROM_AW  tile ROM read address (registered).
- o_color  out  COLOR_W  pixel colour; 0 when transparent.
- o_layer_active  out  1  1 = opaque pixel.
- o_pixel_valid  out  1  one-cycle strobe when o_color and o_layer_active update.
- o_busy  out  1  1 whenever the state is not IDLE.
- o_overrun  out  1  sticky flag: a pixel edge arrived while busy.

## Operation
- Edge detect: r_lcd_last <= i_lcd_clk. The edge signal is i_lcd_clk & ~r_lcd_last. r_lcd_last resets to 1, so no false edge occurs if i_lcd_clk is high at reset release.
- On an edge in IDLE, the block captures x, y, scroll, rotate and mirror together and enters GEN_ADDR.
- On an edge while not IDLE, the edge is ignored and o_overrun is set. The current pixel completes normally.
- Scrolled coordinates: sx = (x + scroll_x) mod 2^X_W, same for sy.
- Tile coordinates: tc = sx >> TILE_SHIFT, with one conditional subtract of MAP_COLS if tc ≥ MAP_COLS. tr = sy >> TILE_SHIFT.
- Local coordinates: u = sx mod T, v = sy mod T.
- States: IDLE → GEN_ADDR → GEN_WAIT (MEM_LAT cycles) → ROM_ADDR → ROM_WAIT (MEM_LAT cycles) → OUT → IDLE.
- GEN_ADDR: o_gen_addr <= tr*MAP_COLS + tc, truncated to GEN_AW.
- ROM_ADDR: sample i_gen_data into idx.
  - If idx == TRANSPARENT, set a transparent flag and leave o_rom_addr unchanged.
  - Otherwise compute the texel position:
    - u' = mirror ? T-1-u : u.
    - 0°: col=u', row=v.
    - 90°: col=v, row=T-1-u'.
    - 180°: col=T-1-u', row=T-1-v.
    - 270°: col=T-1-v, row=u'.
    - o_rom_addr <= idx*T*T + row*T + col.
- OUT: both paths commit here, so latency is uniform.
  - Opaque: o_color <= i_rom_data, o_layer_active <= 1.
  - Transparent: o_color <= 0, o_layer_active <= 0.
  - o_pixel_valid pulses for one cycle in both cases.
- o_overrun is cleared by i_overrun_clr. If a set condition and i_overrun_clr occur in the same cycle, set wins.

## Timing
- D is the i_clk edge at which the pixel edge is detected in IDLE.
- o_gen_addr is valid after D+1.
- i_gen_data is sampled at D+2+MEM_LAT; o_rom_addr is valid after that edge.
- i_rom_data is sampled at D+3+2*MEM_LAT. o_color, o_layer_active and o_pixel_valid update at that same edge.
- Fixed latency is 3+2*MEM_LAT cycles (5 at default), for both opaque and transparent pixels.
- The LCD pixel period must be ≥ 4+2*MEM_LAT i_clk cycles; a shorter period causes overrun.
- Reset (async, any state): state IDLE; all outputs 0, including o_gen_addr, o_rom_addr, o_color, o_layer_active, o_pixel_valid, o_busy and o_overrun; r_lcd_last = 1. The first edge is accepted only after i_lcd_clk has been sampled low.

## Test plan
All scenarios use default parameters.
- Basic opaque pixel: x=5, y=9, scroll 0, rot 0, gen data 3, rom data 0xABCDEF → o_gen_addr=241, o_rom_addr=53. At D+5: o_color=0xABCDEF, o_layer_active=1, one-cycle o_pixel_valid.
- Transparent pixel: gen data 63 → at D+5: o_color=0, o_layer_active=0, o_pixel_valid=1; o_rom_addr keeps its prior value.
- Rotate/mirror: x=1, y=2, idx 0 → rot 0/1/2/3 give o_rom_addr 9/10/6/5; mirror with rot 0 gives 10.
- Scroll wrap: x=476, scroll_x=8, y=0 → tc=121-120=1, so o_gen_addr=1. Also x=510, scroll_x=4 → sx=2, so o_gen_addr=0.
- Overrun: second lcd edge at D+2 → o_overrun=1 and the first pixel still completes at D+5. Pulse i_overrun_clr → o_overrun=0.
- Reset mid-pixel: assert i_rst_n=0 at D+3 → all outputs 0 immediately and no o_pixel_valid. Release reset with i_lcd_clk high → no pixel starts until the next genuine rising edge.

Source files
------------

// File: rtl/tile_layer.sv
// Tile-map layer renderer: scrolls the pixel coordinate, fetches the tile index from the
// generator RAM, then fetches the (mirrored/rotated) texel from the tile ROM.
module tile_layer #(
  parameter int unsigned TILE_SHIFT  = 2,
  parameter int unsigned MAP_COLS    = 120,
  parameter int unsigned X_W         = 9,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned COLOR_W     = 24,
  parameter int unsigned GEN_AW      = 13,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned TRANSPARENT = (1 << IDX_W) - 1,
  parameter int unsigned ROM_AW      = IDX_W + 2 * TILE_SHIFT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_lcd_clk,
  input  logic [X_W-1:0]     i_x,
  input  logic [X_W-1:0]     i_y,
  input  logic [X_W-1:0]     i_scroll_x,
  input  logic [X_W-1:0]     i_scroll_y,
  input  logic [1:0]         i_rotate,
  input  logic               i_mirror,
  input  logic [IDX_W-1:0]   i_gen_data,
  input  logic [COLOR_W-1:0] i_rom_data,
  input  logic               i_overrun_clr,
  output logic [GEN_AW-1:0]  o_gen_addr,
  output logic [ROM_AW-1:0]  o_rom_addr,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_layer_active,
  output logic               o_pixel_valid,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int unsigned TW = X_W - TILE_SHIFT;
  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StGenAddr, StGenWait, StRomAddr, StRomWait, StOut} state_e;

  state_e                state;
  logic                  lcd_last;
  logic [X_W-1:0]        sx, sy;
  logic [1:0]            rot;
  logic                  mirror;
  logic                  transp;
  logic [CW-1:0]         cnt;

  logic                  lcd_edge;
  logic [TW-1:0]         tc_raw, tc, tr;
  logic [31:0]           gen_full;
  logic [TILE_SHIFT-1:0] u, v, u_m, col, row;
  logic [ROM_AW-1:0]     rom_next;

  assign lcd_edge = i_lcd_clk & ~lcd_last;
  assign o_busy   = (state != StIdle);

  // Single conditional subtract wraps the tile column onto the map width.
  assign tc_raw   = sx[X_W-1:TILE_SHIFT];
  assign tc       = (32'(tc_raw) >= MAP_COLS) ? TW'(32'(tc_raw) - MAP_COLS) : tc_raw;
  assign tr       = sy[X_W-1:TILE_SHIFT];
  assign gen_full = 32'(tr) * MAP_COLS + 32'(tc);

  // T-1-n is the bitwise inverse for a TILE_SHIFT-bit local coordinate.
  assign u   = sx[TILE_SHIFT-1:0];
  assign v   = sy[TILE_SHIFT-1:0];
  assign u_m = mirror ? ~u : u;

  always_comb begin
    col = u_m;
    row = v;
    case (rot)
      2'd0: begin col = u_m; row = v;    end
      2'd1: begin col = v;   row = ~u_m; end
      2'd2: begin col = ~u_m; row = ~v;  end
      2'd3: begin col = ~v;  row = u_m;  end
      default: ;
    endcase
  end

  assign rom_next = {i_gen_data, row, col};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= StIdle;
      lcd_last       <= 1'b1;
      sx             <= '0;
      sy             <= '0;
      rot            <= '0;
      mirror         <= 1'b0;
      transp         <= 1'b0;
      cnt            <= '0;
      o_gen_addr     <= '0;
      o_rom_addr     <= '0;
      o_color        <= '0;
      o_layer_active <= 1'b0;
      o_pixel_valid  <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      lcd_last      <= i_lcd_clk;
      o_pixel_valid <= 1'b0;
      if (lcd_edge && state != StIdle) begin
        o_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        o_overrun <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (lcd_edge) begin
            sx     <= i_x + i_scroll_x;
            sy     <= i_y + i_scroll_y;
            rot    <= i_rotate;
            mirror <= i_mirror;
            state  <= StGenAddr;
          end
        end
        StGenAddr: begin
          o_gen_addr <= gen_full[GEN_AW-1:0];
          cnt        <= '0;
          state      <= StGenWait;
        end
        StGenWait: begin
          if (cnt == CW'(MEM_LAT - 1)) state <= StRomAddr;
          else                         cnt   <= cnt + 1'b1;
        end
        StRomAddr: begin
          transp <= (i_gen_data == IDX_W'(TRANSPARENT));
          if (i_gen_data != IDX_W'(TRANSPARENT)) o_rom_addr <= rom_next;
          cnt   <= '0;
          state <= StRomWait;
        end
        StRomWait: begin
          if (cnt == CW'(MEM_LAT - 1)) state <= StOut;
          else                         cnt   <= cnt + 1'b1;
        end
        StOut: begin
          o_color        <= transp ? '0 : i_rom_data;
          o_layer_active <= ~transp;
          o_pixel_valid  <= 1'b1;
          state          <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_layer.sv
// Bench for tile_layer: directed vector table, overrun/reset sequences, and random pixels
// checked against an arithmetic reference model with behavioural memories.
module tb_tile_layer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_lcd_clk;
  logic [8:0]  i_x, i_y, i_scroll_x, i_scroll_y;
  logic [1:0]  i_rotate;
  logic        i_mirror;
  logic [5:0]  i_gen_data;
  logic [23:0] i_rom_data;
  logic        i_overrun_clr;
  logic [12:0] o_gen_addr;
  logic [9:0]  o_rom_addr;
  logic [23:0] o_color;
  logic        o_layer_active, o_pixel_valid, o_busy, o_overrun;

  tile_layer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lcd_clk(i_lcd_clk),
    .i_x(i_x), .i_y(i_y), .i_scroll_x(i_scroll_x), .i_scroll_y(i_scroll_y),
    .i_rotate(i_rotate), .i_mirror(i_mirror), .i_gen_data(i_gen_data),
    .i_rom_data(i_rom_data), .i_overrun_clr(i_overrun_clr),
    .o_gen_addr(o_gen_addr), .o_rom_addr(o_rom_addr), .o_color(o_color),
    .o_layer_active(o_layer_active), .o_pixel_valid(o_pixel_valid),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural memories with one cycle of read latency.
  logic [5:0]  gen_mem [8192];
  logic [23:0] rom_mem [1024];
  always @(posedge i_clk) begin
    i_gen_data <= gen_mem[o_gen_addr];
    i_rom_data <= rom_mem[o_rom_addr];
  end

  int pv_cnt = 0;
  always @(posedge i_clk) if (o_pixel_valid) pv_cnt <= pv_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    int x, y, scx, scy, rot, mir;
    logic [5:0]  gen_val;
    logic [23:0] rom_val;
    int exp_gen, exp_rom;
    logic [23:0] exp_color;
    logic        exp_act;
  } vec_t;

  function automatic vec_t mk(input int x, y, scx, scy, rot, mir, input logic [5:0] g,
                              input logic [23:0] r, input int eg, er,
                              input logic [23:0] ec, input logic ea);
    vec_t t;
    t.x = x; t.y = y; t.scx = scx; t.scy = scy; t.rot = rot; t.mir = mir;
    t.gen_val = g; t.rom_val = r; t.exp_gen = eg; t.exp_rom = er;
    t.exp_color = ec; t.exp_act = ea;
    return t;
  endfunction

  // Reference model from the coordinate rules, T=4, 120 map columns.
  function automatic void model(input int x, y, scx, scy, rot, mir,
                                output int gen, output int texel);
    int sxs, sys, tc, tr, u, v, up, col, row;
    sxs = (x + scx) % 512;
    sys = (y + scy) % 512;
    tc = sxs / 4;
    if (tc >= 120) tc = tc - 120;
    tr = sys / 4;
    gen = (tr * 120 + tc) % 8192;
    u = sxs % 4;
    v = sys % 4;
    up = mir ? 3 - u : u;
    case (rot)
      0:       begin col = up;     row = v;      end
      1:       begin col = v;      row = 3 - up; end
      2:       begin col = 3 - up; row = 3 - v;  end
      default: begin col = 3 - v;  row = up;     end
    endcase
    texel = row * 4 + col;
  endfunction

  task automatic run_pixel(input int x, y, scx, scy, rot, mir,
                           output int g, output int r, output logic [23:0] c,
                           output logic a, output int lat, output logic pv_after);
    @(negedge i_clk);
    i_x = 9'(x); i_y = 9'(y); i_scroll_x = 9'(scx); i_scroll_y = 9'(scy);
    i_rotate = 2'(rot); i_mirror = mir[0];
    i_lcd_clk = 1'b1;
    @(posedge i_clk);               // D
    @(posedge i_clk); #1;           // D+1
    g = int'(o_gen_addr);
    @(posedge i_clk); @(posedge i_clk); #1;  // D+3
    r = int'(o_rom_addr);
    lat = 3;
    while (!o_pixel_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    c = o_color;
    a = o_layer_active;
    @(posedge i_clk); #1;
    pv_after = o_pixel_valid;
    @(negedge i_clk);
    i_lcd_clk = 1'b0;
    repeat (2) @(posedge i_clk);
  endtask

  task automatic check_pixel(input string tag, input int g, r, input logic [23:0] c,
                             input logic a, input int lat, input logic pva,
                             input int eg, er, input logic [23:0] ec, input logic ea);
    check({tag, " gen_addr"}, 32'(g), 32'(eg));
    check({tag, " rom_addr"}, 32'(r), 32'(er));
    check({tag, " color"}, 32'(c), 32'(ec));
    check({tag, " active"}, 32'(a), 32'(ea));
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " valid_one_cycle"}, 32'(pva), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int g, r, lat, eg, et, er, busy_seen, pv_before, prev_rom;
    logic [23:0] c, ec;
    logic a, pva, ea;
    logic [5:0] idx;

    vecs[0] = mk(5, 9, 0, 0, 0, 0, 6'd3, 24'hABCDEF, 241, 53, 24'hABCDEF, 1'b1);
    vecs[1] = mk(5, 9, 0, 0, 0, 0, 6'd63, 24'h123456, 241, 53, 24'h0, 1'b0);
    vecs[2] = mk(1, 2, 0, 0, 0, 0, 6'd0, 24'h000011, 0, 9, 24'h000011, 1'b1);
    vecs[3] = mk(1, 2, 0, 0, 1, 0, 6'd0, 24'h000022, 0, 10, 24'h000022, 1'b1);
    vecs[4] = mk(1, 2, 0, 0, 2, 0, 6'd0, 24'h000033, 0, 6, 24'h000033, 1'b1);
    vecs[5] = mk(1, 2, 0, 0, 3, 0, 6'd0, 24'h000044, 0, 5, 24'h000044, 1'b1);
    vecs[6] = mk(1, 2, 0, 0, 0, 1, 6'd0, 24'h000055, 0, 10, 24'h000055, 1'b1);
    vecs[7] = mk(476, 0, 8, 0, 0, 0, 6'd5, 24'h000066, 1, 80, 24'h000066, 1'b1);
    vecs[8] = mk(510, 0, 4, 0, 0, 0, 6'd7, 24'h000077, 0, 114, 24'h000077, 1'b1);
    vecs[9] = mk(0, 500, 0, 20, 0, 0, 6'd9, 24'h000099, 240, 144, 24'h000099, 1'b1);

    for (int i = 0; i < 8192; i++) gen_mem[i] = 6'd0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 24'd0;
    i_rst_n = 1'b0; i_lcd_clk = 1'b0; i_overrun_clr = 1'b0;
    i_x = '0; i_y = '0; i_scroll_x = '0; i_scroll_y = '0; i_rotate = '0; i_mirror = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset gen_addr", 32'(o_gen_addr), 0);
    check("reset rom_addr", 32'(o_rom_addr), 0);
    check("reset color", 32'(o_color), 0);
    check("reset active", 32'(o_layer_active), 0);
    check("reset valid", 32'(o_pixel_valid), 0);
    check("reset busy", 32'(o_busy), 0);
    check("reset overrun", 32'(o_overrun), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      gen_mem[vecs[i].exp_gen] = vecs[i].gen_val;
      if (vecs[i].exp_act) rom_mem[vecs[i].exp_rom] = vecs[i].rom_val;
      run_pixel(vecs[i].x, vecs[i].y, vecs[i].scx, vecs[i].scy, vecs[i].rot, vecs[i].mir,
                g, r, c, a, lat, pva);
      check_pixel($sformatf("vec%0d", i), g, r, c, a, lat, pva, vecs[i].exp_gen,
                  vecs[i].exp_rom, vecs[i].exp_color, vecs[i].exp_act);
    end

    // Overrun: second lcd edge at D+2, first pixel still completes at D+5
    gen_mem[241] = 6'd3;
    rom_mem[53] = 24'hABCDEF;
    @(negedge i_clk);
    i_x = 9'd5; i_y = 9'd9; i_scroll_x = '0; i_scroll_y = '0; i_rotate = '0; i_mirror = 1'b0;
    i_lcd_clk = 1'b1;
    @(posedge i_clk);               // D
    @(negedge i_clk); i_lcd_clk = 1'b0;
    @(negedge i_clk); i_lcd_clk = 1'b1;
    @(posedge i_clk); #1;           // D+2
    check("overrun set", 32'(o_overrun), 1);
    lat = 2;
    while (!o_pixel_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check("overrun pixel latency", 32'(lat), 5);
    check("overrun pixel color", 32'(o_color), 32'hABCDEF);
    pv_before = pv_cnt;
    repeat (6) @(posedge i_clk);
    #1;
    check("overrun no extra pixel", 32'(pv_cnt), 32'(pv_before + 1));
    check("overrun sticky", 32'(o_overrun), 1);
    @(negedge i_clk); i_lcd_clk = 1'b0; i_overrun_clr = 1'b1;
    @(posedge i_clk); #1;
    check("overrun cleared", 32'(o_overrun), 0);
    @(negedge i_clk); i_overrun_clr = 1'b0;
    repeat (2) @(posedge i_clk);

    // Reset mid-pixel at D+3, released with lcd still high
    @(negedge i_clk);
    i_lcd_clk = 1'b1;
    @(posedge i_clk);               // D
    repeat (3) @(posedge i_clk);    // D+3
    #2;
    pv_before = pv_cnt;
    i_rst_n = 1'b0;
    #1;
    check("midrst gen_addr", 32'(o_gen_addr), 0);
    check("midrst rom_addr", 32'(o_rom_addr), 0);
    check("midrst color", 32'(o_color), 0);
    check("midrst active", 32'(o_layer_active), 0);
    check("midrst busy", 32'(o_busy), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      if (o_busy) busy_seen++;
    end
    check("midrst no valid", 32'(pv_cnt), 32'(pv_before));
    check("midrst no start", 32'(busy_seen), 0);
    @(negedge i_clk); i_lcd_clk = 1'b0;
    repeat (2) @(posedge i_clk);
    run_pixel(5, 9, 0, 0, 0, 0, g, r, c, a, lat, pva);
    check_pixel("after_rst", g, r, c, a, lat, pva, 241, 53, 24'hABCDEF, 1'b1);
    prev_rom = 53;

    // Random pixels against the reference model
    for (int i = 0; i < 8192; i++)
      gen_mem[i] = ($urandom_range(7) == 0) ? 6'd63 : 6'($urandom_range(62));
    for (int i = 0; i < 1024; i++) rom_mem[i] = 24'($urandom);
    for (int i = 0; i < 40; i++) begin
      int x, y, scx, scy, rot, mir;
      x = $urandom_range(511); y = $urandom_range(511);
      scx = $urandom_range(511); scy = $urandom_range(511);
      rot = $urandom_range(3); mir = $urandom_range(1);
      model(x, y, scx, scy, rot, mir, eg, et);
      idx = gen_mem[eg];
      if (idx == 6'd63) begin
        er = prev_rom; ec = 24'd0; ea = 1'b0;
      end else begin
        er = int'(idx) * 16 + et; ec = rom_mem[er]; ea = 1'b1;
      end
      prev_rom = er;
      run_pixel(x, y, scx, scy, rot, mir, g, r, c, a, lat, pva);
      check_pixel($sformatf("rand%0d", i), g, r, c, a, lat, pva, eg, er, ec, ea);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
